// File: rtl/controle_jogo.sv
// Naval-battle game sequencer: button debounce, placement/attack phases,
// save strobes to the matrix banks, shot/hit bookkeeping and win/lose.
module controle_jogo #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int N_SHIPS         = 3,
   parameter int MAX_SHOTS       = 15,
   parameter int HITS_TO_WIN     = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       botao,
   input  logic       power,
   input  logic       overlap,
   input  logic       hit,
   input  logic       already_shot,
   output logic       save_place,
   output logic       save_attack,
   output logic       clear_maps,
   output logic       place_error,
   output logic       shot_error,
   output logic [1:0] phase,
   output logic [2:0] ships_placed,
   output logic [4:0] shots_left,
   output logic [5:0] hits,
   output logic       win,
   output logic       lose
);

   typedef enum logic [1:0] {
      S_OFF    = 2'b00,
      S_PLACE  = 2'b01,
      S_ATTACK = 2'b10,
      S_END    = 2'b11
   } state_t;

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0] SHIPS_END = 3'(N_SHIPS);
   localparam logic [4:0] SHOTS_INIT = 5'(MAX_SHOTS);
   localparam logic [5:0] HITS_END = 6'(HITS_TO_WIN);

   state_t state, state_n;
   logic sync1, sync2, db;
   logic [CW-1:0] cnt;
   logic press;
   logic [2:0] ships_n;
   logic [4:0] shots_n;
   logic [5:0] hits_n;
   logic win_n, lose_n, sp_n, sa_n, pe_n, se_n, clr_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         db    <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= botao;
         sync2 <= sync1;
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Press is flagged in the cycle whose closing edge raises db, so the
   // registered strobe appears right after that edge.
   assign press = sync2 & ~db & (cnt == CNT_LAST);

   always_comb begin
      state_n = state;
      ships_n = ships_placed;
      shots_n = shots_left;
      hits_n  = hits;
      win_n   = win;
      lose_n  = lose;
      sp_n    = 1'b0;
      sa_n    = 1'b0;
      pe_n    = 1'b0;
      se_n    = 1'b0;
      clr_n   = 1'b0;
      if (!power) begin
         state_n = S_OFF;
         ships_n = '0;
         shots_n = '0;
         hits_n  = '0;
         win_n   = 1'b0;
         lose_n  = 1'b0;
         clr_n   = 1'b1;
      end else begin
         unique case (state)
            S_OFF: begin
               state_n = S_PLACE;
               ships_n = '0;
               shots_n = SHOTS_INIT;
               hits_n  = '0;
            end
            S_PLACE: begin
               if (press) begin
                  if (overlap) begin
                     pe_n = 1'b1;
                  end else if (ships_placed < SHIPS_END) begin
                     sp_n    = 1'b1;
                     ships_n = ships_placed + 3'd1;
                     if (ships_n == SHIPS_END) state_n = S_ATTACK;
                  end
               end
            end
            S_ATTACK: begin
               if (press) begin
                  if (already_shot) begin
                     se_n = 1'b1;
                  end else if (shots_left != 5'd0) begin
                     sa_n    = 1'b1;
                     shots_n = shots_left - 5'd1;
                     if (hit && hits < HITS_END) hits_n = hits + 6'd1;
                     // A winning last shot takes priority over running out.
                     if (hits_n == HITS_END) begin
                        state_n = S_END;
                        win_n   = 1'b1;
                     end else if (shots_n == 5'd0) begin
                        state_n = S_END;
                        lose_n  = 1'b1;
                     end
                  end
               end
            end
            S_END: begin
               if (press) begin
                  clr_n   = 1'b1;
                  state_n = S_PLACE;
                  ships_n = '0;
                  shots_n = SHOTS_INIT;
                  hits_n  = '0;
                  win_n   = 1'b0;
                  lose_n  = 1'b0;
               end
            end
            default: state_n = S_OFF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_OFF;
         ships_placed <= '0;
         shots_left   <= '0;
         hits         <= '0;
         win          <= 1'b0;
         lose         <= 1'b0;
         save_place   <= 1'b0;
         save_attack  <= 1'b0;
         place_error  <= 1'b0;
         shot_error   <= 1'b0;
         clear_maps   <= 1'b1;
      end else begin
         state        <= state_n;
         ships_placed <= ships_n;
         shots_left   <= shots_n;
         hits         <= hits_n;
         win          <= win_n;
         lose         <= lose_n;
         save_place   <= sp_n;
         save_attack  <= sa_n;
         place_error  <= pe_n;
         shot_error   <= se_n;
         clear_maps   <= clr_n;
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: directed vector table, latency/bounce sequences
// and random presses checked against a per-press game model.
module tb_controle_jogo;

   localparam int D  = 4;
   localparam int NS = 2;
   localparam int MS = 3;
   localparam int HW = 2;

   logic clk = 1'b0;
   logic reset, botao, power, overlap, hit, already_shot;
   logic save_place, save_attack, clear_maps, place_error, shot_error;
   logic [1:0] phase;
   logic [2:0] ships_placed;
   logic [4:0] shots_left;
   logic [5:0] hits;
   logic win, lose;

   controle_jogo #(
      .DEBOUNCE_CYCLES(D), .N_SHIPS(NS), .MAX_SHOTS(MS), .HITS_TO_WIN(HW)
   ) dut (
      .clk(clk), .reset(reset), .botao(botao), .power(power),
      .overlap(overlap), .hit(hit), .already_shot(already_shot),
      .save_place(save_place), .save_attack(save_attack),
      .clear_maps(clear_maps), .place_error(place_error),
      .shot_error(shot_error), .phase(phase), .ships_placed(ships_placed),
      .shots_left(shots_left), .hits(hits), .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;
   int t_sp = 0, t_sa = 0, t_pe = 0, t_se = 0, t_cm = 0;

   always @(negedge clk) begin
      if (!reset) begin
         t_sp += int'(save_place);
         t_sa += int'(save_attack);
         t_pe += int'(place_error);
         t_se += int'(shot_error);
         t_cm += int'(clear_maps);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_press(input logic ov, input logic ht, input logic as);
      @(negedge clk);
      overlap = ov;
      hit = ht;
      already_shot = as;
      botao = 1'b1;
      repeat (D + 3) @(negedge clk);
      botao = 1'b0;
      repeat (D + 3) @(negedge clk);
   endtask

   typedef struct {
      logic ov, ht, as;
      int ph, sh, sl, hi, w, l;
      int sp, sa, pe, se, cm;
   } vec_t;

   function automatic vec_t mk(input logic ov, ht, as,
                               input int ph, sh, sl, hi, w, l,
                               input int sp, sa, pe, se, cm);
      vec_t v;
      v.ov = ov; v.ht = ht; v.as = as;
      v.ph = ph; v.sh = sh; v.sl = sl; v.hi = hi; v.w = w; v.l = l;
      v.sp = sp; v.sa = sa; v.pe = pe; v.se = se; v.cm = cm;
      return v;
   endfunction

   // game-level model, advanced once per debounced press
   int m_ph, m_sh, m_sl, m_hi, m_w, m_l;
   int e_sp, e_sa, e_pe, e_se, e_cm;

   task automatic model_init();
      m_ph = 1; m_sh = 0; m_sl = MS; m_hi = 0; m_w = 0; m_l = 0;
   endtask

   task automatic model_press(input logic ov, input logic ht, input logic as);
      e_sp = 0; e_sa = 0; e_pe = 0; e_se = 0; e_cm = 0;
      if (m_ph == 1) begin
         if (ov) e_pe = 1;
         else begin
            e_sp = 1;
            m_sh++;
            if (m_sh == NS) m_ph = 2;
         end
      end else if (m_ph == 2) begin
         if (as) e_se = 1;
         else begin
            e_sa = 1;
            m_sl--;
            if (ht) m_hi++;
            if (m_hi == HW) begin m_ph = 3; m_w = 1; end
            else if (m_sl == 0) begin m_ph = 3; m_l = 1; end
         end
      end else if (m_ph == 3) begin
         e_cm = 1;
         model_init();
      end
   endtask

   task automatic cmp_state(input string tag);
      chk({tag, " phase"}, int'(phase), m_ph);
      chk({tag, " ships"}, int'(ships_placed), m_sh);
      chk({tag, " shots"}, int'(shots_left), m_sl);
      chk({tag, " hits"}, int'(hits), m_hi);
      chk({tag, " win"}, int'(win), m_w);
      chk({tag, " lose"}, int'(lose), m_l);
   endtask

   vec_t tbl[13];
   logic [7:0] lat;
   int b_sp, b_sa, b_pe, b_se, b_cm;

   task automatic snap();
      b_sp = t_sp; b_sa = t_sa; b_pe = t_pe; b_se = t_se; b_cm = t_cm;
   endtask

   task automatic power_cycle();
      @(negedge clk);
      power = 1'b0;
      @(posedge clk);
      #1;
      chk("poweroff phase", int'(phase), 0);
      chk("poweroff clear", int'(clear_maps), 1);
      chk("poweroff shots", int'(shots_left), 0);
      @(negedge clk);
      power = 1'b1;
      repeat (3) @(negedge clk);
      model_init();
   endtask

   initial begin
      reset = 1'b1; botao = 1'b0; power = 1'b1;
      overlap = 1'b0; hit = 1'b0; already_shot = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset phase", int'(phase), 0);
      chk("reset clear", int'(clear_maps), 1);
      chk("reset shots", int'(shots_left), 0);
      chk("reset win", int'(win), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("pwrup phase", int'(phase), 1);
      chk("pwrup shots", int'(shots_left), MS);
      chk("pwrup clear", int'(clear_maps), 0);

      // clean press: strobe exactly in the cycle after edge k+D+1
      @(negedge clk);
      botao = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 lat[i] = save_place;
      end
      @(negedge clk);
      botao = 1'b0;
      repeat (D + 3) @(negedge clk);
      chk("latency strobe map", int'(lat), 32);
      chk("latency ships", int'(ships_placed), 1);

      // bouncy press must not be accepted
      snap();
      @(negedge clk);
      botao = 1'b1;
      repeat (3) @(negedge clk);
      botao = 1'b0;
      @(negedge clk);
      botao = 1'b1;
      repeat (3) @(negedge clk);
      botao = 1'b0;
      repeat (D + 4) @(negedge clk);
      chk("bounce strobes", t_sp - b_sp + t_pe - b_pe, 0);
      chk("bounce ships", int'(ships_placed), 1);
      snap();
      botao = 1'b1;
      repeat (6) @(negedge clk);
      botao = 1'b0;
      repeat (D + 3) @(negedge clk);
      chk("stable press strobes", t_sp - b_sp, 1);
      chk("stable press phase", int'(phase), 2);

      power_cycle();

      tbl[0]  = mk(1, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[1]  = mk(0, 0, 0, 1, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 2, 2, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 1, 0, 2, 2, 2, 1, 0, 0, 0, 1, 0, 0, 0);
      tbl[4]  = mk(0, 1, 1, 2, 2, 2, 1, 0, 0, 0, 0, 0, 1, 0);
      tbl[5]  = mk(0, 1, 0, 3, 2, 1, 2, 1, 0, 0, 1, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[7]  = mk(0, 0, 0, 1, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 2, 2, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 2, 2, 2, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 2, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[11] = mk(0, 0, 0, 3, 2, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      tbl[12] = mk(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 13; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         snap();
         do_press(tbl[i].ov, tbl[i].ht, tbl[i].as);
         chk({tag, " phase"}, int'(phase), tbl[i].ph);
         chk({tag, " ships"}, int'(ships_placed), tbl[i].sh);
         chk({tag, " shots"}, int'(shots_left), tbl[i].sl);
         chk({tag, " hits"}, int'(hits), tbl[i].hi);
         chk({tag, " win"}, int'(win), tbl[i].w);
         chk({tag, " lose"}, int'(lose), tbl[i].l);
         chk({tag, " save_place"}, t_sp - b_sp, tbl[i].sp);
         chk({tag, " save_attack"}, t_sa - b_sa, tbl[i].sa);
         chk({tag, " place_error"}, t_pe - b_pe, tbl[i].pe);
         chk({tag, " shot_error"}, t_se - b_se, tbl[i].se);
         chk({tag, " clear_maps"}, t_cm - b_cm, tbl[i].cm);
      end

      // power off mid-attack
      do_press(0, 0, 0);
      do_press(0, 0, 0);
      do_press(0, 1, 0);
      chk("midattack phase", int'(phase), 2);
      power_cycle();
      chk("repower phase", int'(phase), 1);
      chk("repower shots", int'(shots_left), MS);

      // random presses against the game model
      for (int i = 0; i < 60; i++) begin
         logic ov, ht, as;
         string tag;
         tag = $sformatf("rnd%0d", i);
         if ($urandom_range(0, 19) == 0) begin
            power_cycle();
            cmp_state({tag, " pwr"});
         end
         ov = ($urandom_range(0, 3) == 0);
         ht = ($urandom_range(0, 1) == 1);
         as = ($urandom_range(0, 3) == 0);
         snap();
         do_press(ov, ht, as);
         model_press(ov, ht, as);
         cmp_state(tag);
         chk({tag, " save_place"}, t_sp - b_sp, e_sp);
         chk({tag, " save_attack"}, t_sa - b_sa, e_sa);
         chk({tag, " place_error"}, t_pe - b_pe, e_pe);
         chk({tag, " shot_error"}, t_se - b_se, e_se);
         chk({tag, " clear_maps"}, t_cm - b_cm, e_cm);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
